// File: rtl/systolic_pkg.sv
// Shared constants and FSM encoding for the systolic operand feeder and mesh top.
package systolic_pkg;

  localparam int unsigned W_DEFAULT = 8;
  localparam int unsigned ACC_W     = 16;
  localparam int unsigned K_MAX     = 255;
  localparam int unsigned K_W       = $clog2(K_MAX + 1);

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StFeed,
    StFlush
  } state_e;

endpackage

// File: rtl/systolic_feeder_if.sv
// Run-control and A/B vector handshake between a producer and the systolic feeder.
interface systolic_feeder_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = systolic_pkg::W_DEFAULT
);
  import systolic_pkg::*;

  logic             start;
  logic [K_W-1:0]   k_len;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   a_vec;
  logic [N*W-1:0]   b_vec;

  modport master (
    output start, k_len, in_valid, a_vec, b_vec,
    input  in_ready
  );

  modport slave (
    input  start, k_len, in_valid, a_vec, b_vec,
    output in_ready
  );

endinterface

// File: rtl/skew_line.sv
// Zero-reset delay line of DEPTH stages; provides one lane of the mesh-edge skew.
module skew_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Operand injector for the NxN output-stationary mesh: clears, skews K vector pairs onto
// the west/north edges, waits for the wavefront to drain and pulses done.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  systolic_feeder_if.slave bus,
  output logic [N*W-1:0] left_out,
  output logic [N*W-1:0] up_out,
  output logic           arr_clr,
  output logic           busy,
  output logic           done
);

  localparam int unsigned FlushW = $clog2(2 * N);
  // Last PE sees its final pair 2N-1 cycles after the last transfer.
  localparam logic [FlushW-1:0] FlushLast = FlushW'(2 * N - 2);

  state_e              state_q;
  logic [K_W-1:0]      k_q;
  logic [K_W-1:0]      xfer_cnt_q;
  logic [FlushW-1:0]   flush_cnt_q;
  logic                arr_clr_q;
  logic                done_q;
  logic                xfer;

  assign bus.in_ready = (state_q == StFeed);
  assign busy         = (state_q != StIdle);
  assign arr_clr      = arr_clr_q;
  assign done         = done_q;
  assign xfer         = bus.in_valid && (state_q == StFeed);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      xfer_cnt_q  <= '0;
      flush_cnt_q <= '0;
      arr_clr_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      arr_clr_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            k_q        <= bus.k_len;
            xfer_cnt_q <= '0;
            arr_clr_q  <= 1'b1;
            state_q    <= StClear;
          end
        end
        StClear: begin
          flush_cnt_q <= '0;
          state_q     <= (k_q == '0) ? StFlush : StFeed;
        end
        StFeed: begin
          if (xfer) begin
            xfer_cnt_q <= xfer_cnt_q + 1'b1;
            if (xfer_cnt_q == k_q - 1'b1) begin
              flush_cnt_q <= '0;
              state_q     <= StFlush;
            end
          end
        end
        StFlush: begin
          if (flush_cnt_q == FlushLast) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Non-transfer cycles inject zero pairs so idle edges never disturb the accumulators.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;

    assign a_in = xfer ? bus.a_vec[i*W +: W] : '0;
    assign b_in = xfer ? bus.b_vec[i*W +: W] : '0;

    skew_line #(
      .DEPTH (i + 1),
      .W     (W)
    ) u_skew_a (
      .clk  (clk),
      .rst  (rst),
      .din  (a_in),
      .dout (left_out[i*W +: W])
    );

    skew_line #(
      .DEPTH (i + 1),
      .W     (W)
    ) u_skew_b (
      .clk  (clk),
      .rst  (rst),
      .din  (b_in),
      .dout (up_out[i*W +: W])
    );
  end

endmodule
